// File: rtl/id_bypass_scoreboard.sv
// id_bypass_scoreboard: decode-stage operand bypass and hazard interlock.
// Forwarding sources are prioritised per byte lane (index 0 = youngest). A
// per-register in-flight counter interlocks producers that no forwarding bus
// shows.
// Optional feature: define IDB_STALL_CNT_EN to add the stall_cnt output.
module id_bypass_scoreboard #(
  parameter int unsigned NSRC  = 2,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREG  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ds_valid,
  input  logic [4:0]           ds_rs,
  input  logic [4:0]           ds_rt,
  input  logic                 ds_use_rs,
  input  logic                 ds_use_rt,
  input  logic [4:0]           ds_dest,
  input  logic                 ds_gr_we,
  input  logic                 ds_fire,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic [4*NSRC-1:0]    fwd_valid,
  input  logic [5*NSRC-1:0]    fwd_dest,
  input  logic [32*NSRC-1:0]   fwd_data,
  input  logic [NSRC-1:0]      fwd_blk,
  input  logic [3:0]           rf_we,
  input  logic [4:0]           rf_waddr,
  input  logic [31:0]          rf_wdata,
  input  logic                 ws_retire,
  input  logic [4:0]           ws_dest,
  input  logic                 flush,
  output logic [31:0]          rs_value,
  output logic [31:0]          rt_value,
  output logic                 ds_ready_go,
`ifdef IDB_STALL_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  output logic                 sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             inc;
  logic             dec;
  logic             dec_err;
  logic             rs_haz;
  logic             rt_haz;
  logic             issue_haz;

  // Per-lane source selection: youngest matching valid source, then the
  // writeback port, then the regfile. Register 0 always reads as zero.
  function automatic logic [31:0] bypass(
    input logic [4:0]         r,
    input logic [31:0]        rf_data,
    input logic [4*NSRC-1:0]  f_valid,
    input logic [5*NSRC-1:0]  f_dest,
    input logic [32*NSRC-1:0] f_data,
    input logic [3:0]         w_we,
    input logic [4:0]         w_addr,
    input logic [31:0]        w_data
  );
    logic [31:0] val;
    logic        found;
    val = rf_data;
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_we[b] && (w_addr == r)) begin
        val[8*b +: 8] = w_data[8*b +: 8];
      end
      found = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (!found && (f_dest[5*i +: 5] == r) && f_valid[4*i + b]) begin
          val[8*b +: 8] = f_data[32*i + 8*b +: 8];
          found         = 1'b1;
        end
      end
    end
    if (r == 5'd0) begin
      val = '0;
    end
    return val;
  endfunction

  // Operand hazard: the youngest source naming r is still blocked, or r has
  // an in-flight producer that neither a forwarding source nor writeback shows.
  function automatic logic hazard(
    input logic [4:0]       r,
    input logic             use_r,
    input logic [CNT_W-1:0] cnt_r,
    input logic [5*NSRC-1:0] f_dest,
    input logic [NSRC-1:0]  f_blk,
    input logic [3:0]       w_we,
    input logic [4:0]       w_addr
  );
    logic hit;
    logic blk;
    hit = 1'b0;
    blk = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!hit && (f_dest[5*i +: 5] == r)) begin
        hit = 1'b1;
        blk = f_blk[i];
      end
    end
    return use_r && (r != 5'd0) &&
           (blk || ((cnt_r != '0) && !hit && !((|w_we) && (w_addr == r))));
  endfunction

  // Operand values and the stall decision.
  always_comb begin
    rs_value    = bypass(ds_rs, rf_rdata1, fwd_valid, fwd_dest, fwd_data,
                         rf_we, rf_waddr, rf_wdata);
    rt_value    = bypass(ds_rt, rf_rdata2, fwd_valid, fwd_dest, fwd_data,
                         rf_we, rf_waddr, rf_wdata);
    rs_haz      = hazard(ds_rs, ds_use_rs, cnt[ds_rs], fwd_dest, fwd_blk,
                         rf_we, rf_waddr);
    rt_haz      = hazard(ds_rt, ds_use_rt, cnt[ds_rt], fwd_dest, fwd_blk,
                         rf_we, rf_waddr);
    issue_haz   = ds_gr_we && (ds_dest != 5'd0) && (cnt[ds_dest] == CNT_MAX);
    ds_ready_go = !(rs_haz || rt_haz || issue_haz);
  end

  // One-hot increment/decrement requests; a flush cancels the issuing write.
  always_comb begin
    inc     = ds_fire && ds_gr_we && (ds_dest != 5'd0) && !flush;
    dec     = ws_retire && (ws_dest != 5'd0);
    inc_vec = '0;
    dec_vec = '0;
    if (inc) begin
      inc_vec[ds_dest] = 1'b1;
    end
    if (dec) begin
      dec_vec[ws_dest] = 1'b1;
    end
    // A paired inc+dec on the same register nets to zero and is not an error.
    dec_err = dec && (cnt[ws_dest] == '0) && !(inc && (ds_dest == ws_dest));
  end

  // In-flight counters: saturate at both ends, flush clears, reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (flush) begin
          cnt[i] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          if (cnt[i] != CNT_MAX) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] != '0) begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end
      end
    end
  end

  // Sticky underflow flag; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err <= 1'b0;
    end else if (dec_err) begin
      sb_err <= 1'b1;
    end
  end

`ifdef IDB_STALL_CNT_EN
  // Count cycles where a valid instruction is held in ID; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  logic unused_ds_valid;
  assign unused_ds_valid = ds_valid;
`endif

endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// tb_id_bypass_scoreboard: table-driven bypass vectors plus hand-written
// scoreboard sequences for id_bypass_scoreboard (NSRC=2, CNT_W=2, NREG=32).
module tb_id_bypass_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_valid;
  logic [4:0]  ds_rs, ds_rt, ds_dest;
  logic        ds_use_rs, ds_use_rt, ds_gr_we, ds_fire;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [7:0]  fwd_valid;
  logic [9:0]  fwd_dest;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_blk;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_retire;
  logic [4:0]  ws_dest;
  logic        flush;
  logic [31:0] rs_value, rt_value;
  logic        ds_ready_go;
  logic        sb_err;
`ifdef IDB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_bypass_scoreboard #(.NSRC(2), .CNT_W(2), .NREG(32)) dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_rs(ds_rs), .ds_rt(ds_rt), .ds_use_rs(ds_use_rs), .ds_use_rt(ds_use_rt),
    .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_fire(ds_fire),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_blk(fwd_blk), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_retire(ws_retire), .ws_dest(ws_dest), .flush(flush),
    .rs_value(rs_value), .rt_value(rt_value), .ds_ready_go(ds_ready_go),
`ifdef IDB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .sb_err(sb_err)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt;
    logic [31:0] rf1, rf2;
    logic [7:0]  fv;
    logic [9:0]  fd;
    logic [63:0] fdata;
    logic [1:0]  fblk;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_rs, exp_rt;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ds_valid = 1'b0; ds_rs = '0; ds_rt = '0; ds_use_rs = 1'b0; ds_use_rt = 1'b0;
    ds_dest = '0; ds_gr_we = 1'b0; ds_fire = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_valid = '0; fwd_dest = '0; fwd_data = '0; fwd_blk = '0;
    rf_we = '0; rf_waddr = '0; rf_wdata = '0;
    ws_retire = 1'b0; ws_dest = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // name, rs, rt, use_rs, use_rt, rf1, rf2, fv{s1,s0}, fd{s1,s0}, fdata{s1,s0}, blk, we, waddr, wdata, exp_rs, exp_rt, exp_ready
    vecs[0] = '{"lane_prio", 5'd5, 5'd0, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF,
                {4'hF, 4'h3}, {5'd5, 5'd5}, {32'hBBBB2222, 32'hAAAA1111}, 2'b00,
                4'h0, 5'd0, 32'h0, 32'hBBBB1111, 32'h0, 1'b1};
    vecs[1] = '{"load_use", 5'd0, 5'd8, 1'b0, 1'b1, 32'h0, 32'hCAFE0008,
                8'h00, {5'd0, 5'd8}, 64'h0, 2'b01,
                4'h0, 5'd0, 32'h0, 32'h0, 32'hCAFE0008, 1'b0};
    vecs[2] = '{"load_done", 5'd0, 5'd8, 1'b0, 1'b1, 32'h0, 32'hCAFE0008,
                {4'h0, 4'hF}, {5'd0, 5'd8}, {32'h0, 32'h88888888}, 2'b00,
                4'h0, 5'd0, 32'h0, 32'h0, 32'h88888888, 1'b1};
    vecs[3] = '{"wb_partial", 5'd10, 5'd0, 1'b1, 1'b0, 32'hAABBCCDD, 32'h0,
                8'h00, 10'h0, 64'h0, 2'b00,
                4'b0101, 5'd10, 32'h11223344, 32'hAA22CC44, 32'h0, 1'b1};
    vecs[4] = '{"src_over_wb", 5'd10, 5'd0, 1'b1, 1'b0, 32'hAABBCCDD, 32'h0,
                {4'h8, 4'h0}, {5'd10, 5'd0}, {32'h99000000, 32'h0}, 2'b00,
                4'hF, 5'd10, 32'h11223344, 32'h99223344, 32'h0, 1'b1};
    vecs[5] = '{"r0_blk", 5'd0, 5'd0, 1'b1, 1'b0, 32'h00005555, 32'h0,
                {4'h0, 4'hF}, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 2'b01,
                4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[6] = '{"young_wins", 5'd6, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0,
                {4'h0, 4'hF}, {5'd6, 5'd6}, {32'h0, 32'h60606060}, 2'b10,
                4'h0, 5'd0, 32'h0, 32'h60606060, 32'h0, 1'b1};
    vecs[7] = '{"old_blk", 5'd6, 5'd0, 1'b1, 1'b0, 32'h00000606, 32'h0,
                8'h00, {5'd6, 5'd3}, 64'h0, 2'b10,
                4'h0, 5'd0, 32'h0, 32'h00000606, 32'h0, 1'b0};
    vecs[8] = '{"unused_op", 5'd0, 5'd8, 1'b0, 1'b0, 32'h0, 32'h00000808,
                8'h00, {5'd0, 5'd8}, 64'h0, 2'b01,
                4'h0, 5'd0, 32'h0, 32'h0, 32'h00000808, 1'b1};
    vecs[9] = '{"wb_not_r", 5'd11, 5'd12, 1'b1, 1'b0, 32'h0B0B0B0B, 32'h0000000C,
                8'h00, 10'h0, 64'h0, 2'b00,
                4'hF, 5'd12, 32'hFFFFFFFF, 32'h0B0B0B0B, 32'hFFFFFFFF, 1'b1};

    set_idle();
    do_reset();

    #1;
    check("reset_ready", {31'd0, ds_ready_go}, 32'd1);
    check("reset_sb_err", {31'd0, sb_err}, 32'd0);

    // Combinational bypass table with all counters idle.
    for (int k = 0; k < 10; k++) begin
      set_idle();
      ds_rs = vecs[k].rs; ds_rt = vecs[k].rt;
      ds_use_rs = vecs[k].use_rs; ds_use_rt = vecs[k].use_rt;
      rf_rdata1 = vecs[k].rf1; rf_rdata2 = vecs[k].rf2;
      fwd_valid = vecs[k].fv; fwd_dest = vecs[k].fd;
      fwd_data = vecs[k].fdata; fwd_blk = vecs[k].fblk;
      rf_we = vecs[k].we; rf_waddr = vecs[k].waddr; rf_wdata = vecs[k].wdata;
      #2;
      check({vecs[k].name, "_rs"}, rs_value, vecs[k].exp_rs);
      check({vecs[k].name, "_rt"}, rt_value, vecs[k].exp_rt);
      check({vecs[k].name, "_rdy"}, {31'd0, ds_ready_go}, {31'd0, vecs[k].exp_ready});
      tick();
    end

    // Invisible producer on r9.
    set_idle();
    ds_fire = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd9;
    tick();
    set_idle();
    ds_rs = 5'd9; ds_use_rs = 1'b1;
    #1;
    check("inv_stall", {31'd0, ds_ready_go}, 32'd0);
    rf_we = 4'h1; rf_waddr = 5'd9;
    #1;
    check("inv_wb_cover", {31'd0, ds_ready_go}, 32'd1);
    rf_we = 4'h0; fwd_dest = {5'd0, 5'd9};
    #1;
    check("inv_src_visible", {31'd0, ds_ready_go}, 32'd1);
    fwd_dest = '0;
    ws_retire = 1'b1; ws_dest = 5'd9;
    tick();
    ws_retire = 1'b0;
    #1;
    check("inv_retired", {31'd0, ds_ready_go}, 32'd1);
    check("inv_no_err", {31'd0, sb_err}, 32'd0);

    // Saturation on r3.
    set_idle();
    ds_fire = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd3;
    tick(); tick();
    #1;
    check("sat_cnt2_issue", {31'd0, ds_ready_go}, 32'd1);
    tick();
    ds_fire = 1'b0;
    #1;
    check("sat_full_issue", {31'd0, ds_ready_go}, 32'd0);
    ds_fire = 1'b1; ws_retire = 1'b1; ws_dest = 5'd3;
    tick();
    ds_fire = 1'b0; ws_retire = 1'b0;
    #1;
    check("sat_pair_keeps", {31'd0, ds_ready_go}, 32'd0);
    ws_retire = 1'b1;
    tick();
    ws_retire = 1'b0;
    #1;
    check("sat_after_retire", {31'd0, ds_ready_go}, 32'd1);
    ds_gr_we = 1'b0; ds_rs = 5'd3; ds_use_rs = 1'b1;
    #1;
    check("sat_operand_stall", {31'd0, ds_ready_go}, 32'd0);

    // r0 retire is ignored; retire of idle r4 raises the sticky error.
    set_idle();
    ws_retire = 1'b1; ws_dest = 5'd0;
    tick();
    check("err_r0_ignored", {31'd0, sb_err}, 32'd0);
    ws_dest = 5'd4;
    tick();
    ws_retire = 1'b0;
    check("err_set", {31'd0, sb_err}, 32'd1);
    tick(); tick();
    check("err_sticky", {31'd0, sb_err}, 32'd1);

    // Flush: r7 at 2, flush with a simultaneous fire to r7.
    set_idle();
    ds_fire = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd7;
    tick(); tick();
    ds_fire = 1'b0; ds_gr_we = 1'b0;
    ds_rs = 5'd7; ds_use_rs = 1'b1;
    #1;
    check("flush_pre_stall", {31'd0, ds_ready_go}, 32'd0);
    ds_fire = 1'b1; ds_gr_we = 1'b1; flush = 1'b1;
    tick();
    ds_fire = 1'b0; flush = 1'b0;
    #1;
    check("flush_cleared", {31'd0, ds_ready_go}, 32'd1);
    ds_rs = 5'd3;
    #1;
    check("flush_r3_cleared", {31'd0, ds_ready_go}, 32'd1);
    check("flush_keeps_err", {31'd0, sb_err}, 32'd1);

    // Reset mid-operation drops in-flight state and the error flag.
    set_idle();
    ds_fire = 1'b1; ds_gr_we = 1'b1; ds_dest = 5'd12;
    tick();
    set_idle();
    ds_rt = 5'd12; ds_use_rt = 1'b1;
    #1;
    check("rst_pre_stall", {31'd0, ds_ready_go}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_no_hazard", {31'd0, ds_ready_go}, 32'd1);
    check("rst_err_clear", {31'd0, sb_err}, 32'd0);
    fwd_dest = {5'd0, 5'd12}; fwd_blk = 2'b01;
    #1;
    check("rst_blk_still", {31'd0, ds_ready_go}, 32'd0);

`ifdef IDB_STALL_CNT_EN
    set_idle();
    do_reset();
    check("stall_cnt_reset", stall_cnt, 32'd0);
    ds_valid = 1'b1; ds_rs = 5'd8; ds_use_rs = 1'b1;
    fwd_dest = {5'd0, 5'd8}; fwd_blk = 2'b01;
    repeat (5) tick();
    ds_valid = 1'b0;
    check("stall_cnt_5", stall_cnt, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_cnt_flush", stall_cnt, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stall_cnt_cleared", stall_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_bypass_scoreboard.md
Name: id_bypass_scoreboard

Overview:
Parametrised operand-bypass and hazard-interlock unit for the decode stage. It replaces the fixed EXE/MEM forwarding and block logic with NSRC prioritised byte-lane forwarding sources. It adds a per-register in-flight write scoreboard so that producers not visible on any forwarding bus (long-latency units, extra pipeline stages) are still interlocked. It sits between the regfile read ports and the ds_to_es bus, and drives ds_ready_go.

Parameters:
NSRC, 2, number of forwarding sources; index 0 is the youngest (EXE), higher indices are older.
CNT_W, 2, width of each per-register in-flight counter; maximum count is 2^CNT_W-1.
NREG, 32, number of architectural GPRs; register 0 is hardwired zero.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ds_valid  in  1  decode stage holds a valid instruction
ds_rs  in  5  source register 1 address
ds_rt  in  5  source register 2 address
ds_use_rs  in  1  instruction reads rs
ds_use_rt  in  1  instruction reads rt
ds_dest  in  5  destination register
ds_gr_we  in  1  instruction writes a GPR
ds_fire  in  1  instruction leaves ID this cycle (ds_to_es_valid && es_allowin)
rf_rdata1  in  32  regfile data for rs
rf_rdata2  in  32  regfile data for rt
fwd_valid  in  4*NSRC  per-source byte-lane data-valid
fwd_dest  in  5*NSRC  per-source destination
fwd_data  in  32*NSRC  per-source result
fwd_blk  in  NSRC  source targets fwd_dest but its data is not yet available
rf_we  in  4  writeback byte write enables
rf_waddr  in  5  writeback address
rf_wdata  in  32  writeback data
ws_retire  in  1  an instruction counted by the scoreboard commits at WB this cycle
ws_dest  in  5  destination of the retiring instruction
flush  in  1  discard all in-flight state
rs_value  out  32  bypassed rs operand
rt_value  out  32  bypassed rt operand
ds_ready_go  out  1  no hazard; ID may advance
sb_err  out  1  sticky: retire seen with counter already 0

Behaviour:
- Outputs are combinational except the counters and sb_err.
- Reset clears all counters and sb_err to 0.
- Bypass is selected per byte lane b and per operand r:
  - Take the lowest-index source i with fwd_dest[i]==r and fwd_valid[i][b].
  - Otherwise take writeback, if rf_we[b] and rf_waddr==r.
  - Otherwise take regfile data.
  - If r==0 the value is 0 and no hazard is raised.
- Operand hazard, for each used operand r!=0; any one of these raises it:
  - (a) fwd_blk[i] is set for the lowest-index source i whose fwd_dest==r.
  - (b) cnt[r]!=0 and no source has fwd_dest==r and writeback does not cover r.
- Issue hazard: ds_gr_we, ds_dest!=0 and cnt[ds_dest] is at its maximum value.
- ds_ready_go = !(any operand hazard or issue hazard). It does not depend on ds_valid.
- Scoreboard update, at the clock edge:
  - inc = ds_fire && ds_gr_we && ds_dest!=0.
  - dec = ws_retire && ws_dest!=0.
  - Same register incremented and decremented in one cycle: counter unchanged.
  - dec on a counter already at 0: counter stays 0 and sb_err is set.
  - Counters never wrap.
- Flush (synchronous) clears all counters; it does not clear sb_err. A ds_fire in the same cycle is ignored. Reset has priority over flush.
- Reset mid-operation drops all in-flight state. The first cycle after reset shows no hazard unless a fwd_blk is active.

Optional Feature:
IDB_STALL_CNT_EN: when defined, adds output stall_cnt[31:0]. It increments on every cycle with ds_valid && !ds_ready_go, wraps at 2^32-1 to 0, is cleared by reset and is not cleared by flush. When undefined, the port and counter do not exist.

Test Plan:
- Byte-lane priority: NSRC=2, src0 dest=5 valid=4'b0011 data=0xAAAA1111, src1 dest=5 valid=4'b1111 data=0xBBBB2222, ds_rs=5 -> rs_value=0xBBBB1111, ds_ready_go=1.
- Load-use block: fwd_blk[0]=1 with fwd_dest[0]=8, ds_rt=8, ds_use_rt=1 -> ds_ready_go=0; drop fwd_blk and set fwd_valid[0]=4'hF -> ds_ready_go=1.
- Invisible producer: fire with dest=9, no source matches 9, next instruction reads 9 -> stall. Pulse ws_retire with ws_dest=9 -> cnt[9]=0 and ds_ready_go=1 the following cycle.
- Counter saturation, CNT_W=2: fire three writes to r3 -> cnt=3; a fourth instruction with dest=3 -> ds_ready_go=0. A same-cycle fire plus retire of r3 keeps cnt=3.
- r0 and error: ds_rs=0 while src0 dest=0 has fwd_blk=1 -> rs_value=0, no stall. ws_retire with ws_dest=4 and cnt[4]=0 -> sb_err=1 and it stays set.
- Flush and reset: cnt[7]=2, assert flush -> all counters 0 next cycle. With IDB_STALL_CNT_EN, 5 stalled cycles -> stall_cnt=5; reset -> stall_cnt=0.
